// File: rtl/affine_fetch.sv
// Instruction fetch stage with halt and operator-wait handling.
// A registered instruction word feeds the decoder, and the PC addresses the program ROM combinationally.
module affine_fetch #(
    parameter int              A       = 2,
    parameter int              W_OP    = 6,
    parameter int              W_INST  = 28,
    parameter logic [W_OP-1:0] OP_WAIT = 6'h3F
) (
    input  logic              clk,
    input  logic              nReset,
    output logic [A-1:0]      rom_addr,
    input  logic [W_INST-1:0] rom_data,
    input  logic              sw_go,
    input  logic              dec_halt,
    output logic [W_INST-1:0] inst,
    output logic              inst_valid,
    output logic [A-1:0]      pc,
    output logic              halted
);

    typedef enum logic [1:0] {RUN, WAIT_HI, WAIT_LO, HALT} state_t;

    state_t state, next_state;
    logic   go_meta, go_s;
    logic   valid;
    logic   is_wait;
    logic   load_fetch;
    logic   clear_valid;

    assign rom_addr = pc;
    assign is_wait  = valid && (inst[W_INST-1 -: W_OP] == OP_WAIT);

    // sw_go comes from a physical switch, so it is resynchronised before use
    always_ff @(posedge clk) begin
        if (!nReset) begin
            go_meta <= 1'b0;
            go_s    <= 1'b0;
        end else begin
            go_meta <= sw_go;
            go_s    <= go_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Halt outranks wait when the decoder flags both on one instruction
    always_comb begin
        next_state = state;
        unique case (state)
            RUN: begin
                if (valid && dec_halt) begin
                    next_state = HALT;
                end else if (is_wait) begin
                    next_state = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (go_s) begin
                    next_state = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!go_s) begin
                    next_state = RUN;
                end
            end
            HALT: next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        load_fetch  = 1'b0;
        clear_valid = 1'b0;
        inst_valid  = 1'b0;
        halted      = 1'b0;
        unique case (state)
            RUN: begin
                inst_valid  = valid && !is_wait;
                clear_valid = valid && dec_halt;
                load_fetch  = !(valid && dec_halt) && !is_wait;
            end
            WAIT_LO: load_fetch = !go_s;
            HALT:    halted     = 1'b1;
            default: load_fetch = 1'b0;
        endcase
    end

    // pc wraps naturally at 2^A with no bubble
    always_ff @(posedge clk) begin
        if (!nReset) begin
            pc    <= '0;
            inst  <= '0;
            valid <= 1'b0;
        end else if (load_fetch) begin
            inst  <= rom_data;
            pc    <= pc + A'(1);
            valid <= 1'b1;
        end else if (clear_valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_affine_fetch.sv
// Directed testbench for affine_fetch: streaming, halt, operator wait, reset priority and wrap-around.
module tb_affine_fetch;

    localparam int A      = 2;
    localparam int W_INST = 28;

    localparam logic [W_INST-1:0] I0 = 28'h0100001;
    localparam logic [W_INST-1:0] I1 = 28'h0200002;
    localparam logic [W_INST-1:0] I2 = 28'h0300003;
    localparam logic [W_INST-1:0] I3 = 28'h0400004;
    localparam logic [W_INST-1:0] WI = 28'hFC00005;

    logic              clk;
    logic              nReset;
    logic [A-1:0]      rom_addr;
    logic [W_INST-1:0] rom_data;
    logic              sw_go;
    logic              dec_halt;
    logic [W_INST-1:0] inst;
    logic              inst_valid;
    logic [A-1:0]      pc;
    logic              halted;

    logic [W_INST-1:0] rom [4];
    logic              halt_en;
    logic [W_INST-1:0] halt_inst;

    int total = 0;
    int bad   = 0;

    affine_fetch dut (
        .clk        (clk),
        .nReset     (nReset),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sw_go      (sw_go),
        .dec_halt   (dec_halt),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM and a stand-in decoder that flags halt on one chosen word
    assign rom_data = rom[rom_addr];
    assign dec_halt = halt_en && (inst == halt_inst);

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic restart();
        nReset = 1'b0;
        applyStimulus(1);
        nReset = 1'b1;
    endtask

    initial begin
        logic [W_INST-1:0] exp_stream [5];
        logic [A-1:0]      exp_pc [5];

        nReset    = 1'b0;
        sw_go     = 1'b0;
        halt_en   = 1'b0;
        halt_inst = I2;
        rom[0] = I0; rom[1] = I1; rom[2] = I2; rom[3] = I3;

        $display("[TB] reset state");
        applyStimulus(2);
        checkOutput("rst_pc",       32'(pc),         32'd0);
        checkOutput("rst_inst",     32'(inst),       32'd0);
        checkOutput("rst_valid",    32'(inst_valid), 32'd0);
        checkOutput("rst_halted",   32'(halted),     32'd0);
        checkOutput("rst_rom_addr", 32'(rom_addr),   32'd0);

        $display("[TB] streaming with wrap");
        exp_stream = '{I0, I1, I2, I3, I0};
        exp_pc     = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        nReset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("stream_inst%0d", i),  32'(inst),       32'(exp_stream[i]));
            checkOutput($sformatf("stream_pc%0d", i),    32'(pc),         32'(exp_pc[i]));
            checkOutput($sformatf("stream_valid%0d", i), 32'(inst_valid), 32'd1);
            checkOutput($sformatf("stream_addr%0d", i),  32'(rom_addr),   32'(exp_pc[i]));
        end

        $display("[TB] halt");
        restart();
        applyStimulus(3);
        checkOutput("halt_pre_inst", 32'(inst), 32'(I2));
        halt_en = 1'b1;
        applyStimulus(1);
        checkOutput("halt_halted", 32'(halted),     32'd1);
        checkOutput("halt_valid",  32'(inst_valid), 32'd0);
        checkOutput("halt_pc",     32'(pc),         32'd3);
        for (int i = 0; i < 20; i++) begin
            sw_go = ~sw_go;
            applyStimulus(1);
        end
        sw_go = 1'b0;
        checkOutput("halt_hold_halted", 32'(halted),     32'd1);
        checkOutput("halt_hold_valid",  32'(inst_valid), 32'd0);
        checkOutput("halt_hold_pc",     32'(pc),         32'd3);
        checkOutput("halt_hold_inst",   32'(inst),       32'(I2));
        halt_en = 1'b0;

        $display("[TB] operator wait");
        rom[1] = WI;
        restart();
        applyStimulus(1);
        checkOutput("wait_first_inst", 32'(inst), 32'(I0));
        applyStimulus(1);
        checkOutput("wait_inst",  32'(inst),       32'(WI));
        checkOutput("wait_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("wait_idle_valid%0d", i), 32'(inst_valid), 32'd0);
            checkOutput($sformatf("wait_idle_pc%0d", i),    32'(pc),         32'd2);
        end
        sw_go = 1'b1;
        applyStimulus(5);
        checkOutput("wait_press_pc",    32'(pc),         32'd2);
        checkOutput("wait_press_valid", 32'(inst_valid), 32'd0);
        sw_go = 1'b0;
        applyStimulus(2);
        checkOutput("wait_rel2_pc",    32'(pc),         32'd2);
        checkOutput("wait_rel2_valid", 32'(inst_valid), 32'd0);
        applyStimulus(1);
        checkOutput("wait_rel3_inst",  32'(inst),       32'(I2));
        checkOutput("wait_rel3_valid", 32'(inst_valid), 32'd1);
        checkOutput("wait_rel3_pc",    32'(pc),         32'd3);

        $display("[TB] reset during wait");
        restart();
        applyStimulus(3);
        checkOutput("mid_inst_before", 32'(inst), 32'(WI));
        nReset = 1'b0;
        applyStimulus(1);
        checkOutput("mid_rst_pc",     32'(pc),         32'd0);
        checkOutput("mid_rst_valid",  32'(inst_valid), 32'd0);
        checkOutput("mid_rst_halted", 32'(halted),     32'd0);
        nReset = 1'b1;
        applyStimulus(1);
        checkOutput("mid_rel_inst",  32'(inst),       32'(I0));
        checkOutput("mid_rel_valid", 32'(inst_valid), 32'd1);

        $display("[TB] halt over wait priority");
        halt_inst = WI;
        halt_en   = 1'b1;
        restart();
        applyStimulus(3);
        checkOutput("prio_halted", 32'(halted), 32'd1);
        sw_go = 1'b1;
        applyStimulus(5);
        sw_go = 1'b0;
        applyStimulus(5);
        checkOutput("prio_hold_halted", 32'(halted),     32'd1);
        checkOutput("prio_hold_pc",     32'(pc),         32'd2);
        checkOutput("prio_hold_inst",   32'(inst),       32'(WI));
        checkOutput("prio_hold_valid",  32'(inst_valid), 32'd0);
        halt_en = 1'b0;

        $display("[TB] wait at last address");
        rom[1] = I1;
        rom[3] = WI;
        restart();
        applyStimulus(4);
        checkOutput("wrap_wait_inst", 32'(inst), 32'(WI));
        checkOutput("wrap_wait_pc",   32'(pc),   32'd0);
        applyStimulus(1);
        sw_go = 1'b1;
        applyStimulus(5);
        sw_go = 1'b0;
        applyStimulus(3);
        checkOutput("wrap_inst",  32'(inst),       32'(I0));
        checkOutput("wrap_pc",    32'(pc),         32'd1);
        checkOutput("wrap_valid", 32'(inst_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
